// File: rtl/lane_block_ram_pkg.sv
// Shared types and elaboration helpers for the lane-enabled block RAM.
package block_ram_package;

  typedef enum logic {
    STATE_CLEARING = 1'b0,
    STATE_READY    = 1'b1
  } state_t;

  function automatic int lanes(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

  function automatic bit params_legal(input int data_width, input int data_depth,
                                      input int lane_width, input int pipelined_output,
                                      input int read_during_write);
    return (lane_width > 0) && (data_width >= lane_width) &&
           (data_width % lane_width == 0) && (data_depth >= 2) &&
           (pipelined_output inside {0, 1}) && (read_during_write inside {0, 1});
  endfunction

endpackage

// File: rtl/lane_block_ram_read_pipeline.sv
// Read-result registers: one mandatory stage plus an optional second stage.
module block_ram_read_pipeline #(
  parameter int DATA_WIDTH       = 32,
  parameter int PIPELINED_OUTPUT = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vld_p0,
  input  logic [DATA_WIDTH-1:0] data_p0,
  output logic                  read_valid,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // p0 -> p1: data only loads on a valid read so it holds between strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) data_p1 <= data_p0;
    end
  end

  if (PIPELINED_OUTPUT != 0) begin : g_stage_p2
    logic                  vld_p2;
    logic [DATA_WIDTH-1:0] data_p2;

    // p1 -> p2
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_p2  <= 1'b0;
        data_p2 <= '0;
      end else begin
        vld_p2 <= vld_p1;
        if (vld_p1) data_p2 <= data_p1;
      end
    end

    assign read_valid = vld_p2;
    assign read_data  = data_p2;
  end else begin : g_stage_p1
    assign read_valid = vld_p1;
    assign read_data  = data_p1;
  end

endmodule

// File: rtl/lane_block_ram.sv
// One-write/one-read block RAM with lane write enables, read-during-write
// selection and a sequential zeroing sweep after reset or clear.
module lane_block_ram
  import block_ram_package::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int DATA_DEPTH        = 4096,
  parameter int LANE_WIDTH        = 8,
  parameter int PIPELINED_OUTPUT  = 0,
  parameter int READ_DURING_WRITE = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             clear,
  output logic                             ready,
  input  logic                             write_enable,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] write_lane_enable,
  input  logic [$clog2(DATA_DEPTH)-1:0]    write_address,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             read_enable,
  input  logic [$clog2(DATA_DEPTH)-1:0]    read_address,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic                             read_valid
);

  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH);
  localparam int LANES      = lanes(DATA_WIDTH, LANE_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT  = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDRESS = ADDR_WIDTH'(DATA_DEPTH - 1);

  if (!params_legal(DATA_WIDTH, DATA_DEPTH, LANE_WIDTH, PIPELINED_OUTPUT, READ_DURING_WRITE))
  begin : g_illegal_params
    $error("lane_block_ram: illegal parameter combination");
  end

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pointer, pointer_next;
  logic                    sweep;
  logic                    write_accept;
  logic                    vld_p0;
  logic [DATA_WIDTH-1:0]   data_p0;
  logic [DATA_WIDTH-1:0]   mem [DATA_DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= STATE_CLEARING;
      pointer <= '0;
    end else begin
      state   <= state_next;
      pointer <= pointer_next;
    end
  end

  always_comb begin
    state_next   = state;
    pointer_next = pointer;
    ready        = 1'b0;
    sweep        = 1'b0;
    case (state)
      STATE_CLEARING: begin
        sweep        = 1'b1;
        pointer_next = pointer + 1'b1;
        if (pointer == LAST_ADDRESS) begin
          state_next   = STATE_READY;
          pointer_next = '0;
        end
      end
      STATE_READY: begin
        ready = 1'b1;
        if (clear) begin
          state_next   = STATE_CLEARING;
          pointer_next = '0;
        end
      end
      default: state_next = STATE_CLEARING;
    endcase
  end

  // Out-of-range writes are dropped here so they can never alias a real entry
  assign write_accept = write_enable & ready & ({1'b0, write_address} < DEPTH_LIMIT);
  assign vld_p0       = read_enable & ready;

  always_ff @(posedge clock) begin
    if (sweep) begin
      mem[pointer] <= '0;
    end else if (write_accept) begin
      for (int l = 0; l < LANES; l++) begin
        if (write_lane_enable[l])
          mem[write_address][l*LANE_WIDTH +: LANE_WIDTH] <= write_data[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_comb begin
    data_p0 = '0;
    if ({1'b0, read_address} < DEPTH_LIMIT) begin
      data_p0 = mem[read_address];
      if (READ_DURING_WRITE != 0 && write_accept && write_address == read_address) begin
        for (int l = 0; l < LANES; l++) begin
          if (write_lane_enable[l])
            data_p0[l*LANE_WIDTH +: LANE_WIDTH] = write_data[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  block_ram_read_pipeline #(
    .DATA_WIDTH      (DATA_WIDTH),
    .PIPELINED_OUTPUT(PIPELINED_OUTPUT)
  ) u_read_pipeline (
    .clock     (clock),
    .reset     (reset),
    .vld_p0    (vld_p0),
    .data_p0   (data_p0),
    .read_valid(read_valid),
    .read_data (read_data)
  );

endmodule

// File: tb/tb_lane_block_ram.sv
// Two instances share stimulus: (latency 1, old-data) and (latency 2, merged new-data).
module tb_lane_block_ram;

  localparam int DEPTH = 12;
  localparam int AW    = 4;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic          write_enable;
  logic [3:0]    write_lane_enable;
  logic [AW-1:0] write_address;
  logic [31:0]   write_data;
  logic          read_enable;
  logic [AW-1:0] read_address;
  logic          ready_a, ready_b;
  logic [31:0]   read_data_a, read_data_b;
  logic          read_valid_a, read_valid_b;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] model[DEPTH];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  lane_block_ram #(
    .DATA_WIDTH(32), .DATA_DEPTH(DEPTH), .LANE_WIDTH(8),
    .PIPELINED_OUTPUT(0), .READ_DURING_WRITE(0)
  ) dut_a (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready_a),
    .write_enable(write_enable), .write_lane_enable(write_lane_enable),
    .write_address(write_address), .write_data(write_data),
    .read_enable(read_enable), .read_address(read_address),
    .read_data(read_data_a), .read_valid(read_valid_a)
  );

  lane_block_ram #(
    .DATA_WIDTH(32), .DATA_DEPTH(DEPTH), .LANE_WIDTH(8),
    .PIPELINED_OUTPUT(1), .READ_DURING_WRITE(1)
  ) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready_b),
    .write_enable(write_enable), .write_lane_enable(write_lane_enable),
    .write_address(write_address), .write_data(write_data),
    .read_enable(read_enable), .read_address(read_address),
    .read_data(read_data_b), .read_valid(read_valid_b)
  );

  // Scoreboard: every strobe must match the queue head at its due cycle
  always @(negedge clock) begin
    if (!reset) begin
      if (read_valid_a || (qa.size() > 0 && qa[0].due == cyc)) begin
        checks++;
        assert (qa.size() != 0) else begin
          failures++;
          $error("FAIL spurious_a observed valid=%0b data=%h cyc=%0d expected no strobe",
                 read_valid_a, read_data_a, cyc);
        end
        if (qa.size() != 0) begin
          exp_t e;
          e = qa.pop_front();
          assert (read_valid_a === 1'b1 && e.due == cyc && read_data_a === e.data) else begin
            failures++;
            $error("FAIL read_a observed valid=%0b data=%h cyc=%0d expected data=%h due=%0d",
                   read_valid_a, read_data_a, cyc, e.data, e.due);
          end
        end
      end
      if (read_valid_b || (qb.size() > 0 && qb[0].due == cyc)) begin
        checks++;
        assert (qb.size() != 0) else begin
          failures++;
          $error("FAIL spurious_b observed valid=%0b data=%h cyc=%0d expected no strobe",
                 read_valid_b, read_data_b, cyc);
        end
        if (qb.size() != 0) begin
          exp_t e;
          e = qb.pop_front();
          assert (read_valid_b === 1'b1 && e.due == cyc && read_data_b === e.data) else begin
            failures++;
            $error("FAIL read_b observed valid=%0b data=%h cyc=%0d expected data=%h due=%0d",
                   read_valid_b, read_data_b, cyc, e.data, e.due);
          end
        end
      end
    end
  end

  task automatic step(input logic we, input logic [3:0] le, input logic [AW-1:0] wa,
                      input logic [31:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic clr, input bit acc);
    logic [31:0] ea, eb;
    @(negedge clock);
    write_enable = we; write_lane_enable = le; write_address = wa; write_data = wd;
    read_enable = re; read_address = ra; clear = clr;
    if (acc) begin
      if (re) begin
        ea = (int'(ra) < DEPTH) ? model[ra] : 32'h0;
        eb = ea;
        if (we && wa == ra && int'(wa) < DEPTH)
          for (int l = 0; l < 4; l++) if (le[l]) eb[l*8 +: 8] = wd[l*8 +: 8];
        qa.push_back('{ea, cyc + 1});
        qb.push_back('{eb, cyc + 2});
      end
      if (we && int'(wa) < DEPTH)
        for (int l = 0; l < 4; l++) if (le[l]) model[wa][l*8 +: 8] = wd[l*8 +: 8];
      if (clr)
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] le, input logic [31:0] d);
    step(1'b1, le, a, d, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 4'h0, '0, 32'h0, 1'b1, a, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, '0, 32'h0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic wait_ready(input int start, input int edges, input string tag);
    int seen;
    seen = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (ready_a === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    checks++;
    assert (seen >= 0 && seen - start == edges && ready_b === ready_a) else begin
      failures++;
      $error("FAIL %s observed edges=%0d ready_b=%0b expected edges=%0d", tag,
             (seen < 0) ? -1 : seen - start, ready_b, edges);
    end
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    assert (read_valid_a === 1'b0 && read_valid_b === 1'b0 &&
            ready_a === 1'b0 && ready_b === 1'b0) else begin
      failures++;
      $error("FAIL %s observed valid=%0b/%0b ready=%0b/%0b expected all 0", tag,
             read_valid_a, read_valid_b, ready_a, ready_b);
    end
  endtask

  initial begin
    int c;
    reset = 1'b1; clear = 1'b0; write_enable = 1'b0; write_lane_enable = '0;
    write_address = '0; write_data = '0; read_enable = 1'b0; read_address = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    repeat (3) @(negedge clock);
    #1;
    check_quiet("reset_state");
    checks++;
    assert (read_data_a === 32'h0 && read_data_b === 32'h0) else begin
      failures++;
      $error("FAIL reset_data observed %h/%h expected 00000000", read_data_a, read_data_b);
    end

    @(negedge clock);
    reset = 1'b0;
    wait_ready(cyc, DEPTH, "reset_release");
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));

    // lane merge, write-to-read back to back
    wr(4'd5, 4'hF, 32'hAABB_CCDD);
    wr(4'd5, 4'b0101, 32'h1122_3344);
    rd(4'd5);

    // same-address read during write
    step(1'b1, 4'b0011, 4'd7, 32'hFFFF_FFFF, 1'b1, 4'd7, 1'b0, 1'b1);
    rd(4'd7);

    for (int a = 0; a < DEPTH; a++) wr(AW'(a), 4'hF, 32'(a + 1));
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));

    // clear with a read in the same cycle, then requests while not ready
    step(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'd3, 1'b1, 1'b1);
    c = cyc;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'hF, 4'd0, 32'hDEAD_BEEF, 1'b1, 4'd0, 1'b1, 1'b0);
      checks++;
      assert (ready_a === 1'b0 && ready_b === 1'b0) else begin
        failures++;
        $error("FAIL clear_ready_low observed %0b/%0b expected 0", ready_a, ready_b);
      end
    end
    idle();
    wait_ready(c, DEPTH + 1, "clear_duration");
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));

    // out-of-range write and reads
    step(1'b1, 4'hF, 4'd13, 32'h5555_5555, 1'b1, 4'd13, 1'b0, 1'b1);
    rd(4'd12);
    rd(4'd15);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));

    // reset at sweep pointer 8
    wr(4'd10, 4'hF, 32'h1234_5678);
    step(1'b0, 4'h0, '0, 32'h0, 1'b0, '0, 1'b1, 1'b1);
    c = cyc;
    repeat (8) idle();
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_quiet("reset_mid_sweep");
    @(negedge clock);
    reset = 1'b0;
    wait_ready(cyc, DEPTH, "sweep_restart");
    rd(4'd10);
    rd(4'd9);

    // reset with reads in flight
    wr(4'd2, 4'hF, 32'h2222_2222);
    rd(4'd2);
    rd(4'd2);
    idle();
    #2 reset = 1'b1;
    qa.delete();
    qb.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    #1 check_quiet("reset_in_flight");
    @(negedge clock);
    reset = 1'b0;
    wait_ready(cyc, DEPTH, "ready_after_flush");
    rd(4'd2);

    repeat (4) idle();
    checks++;
    assert (qa.size() == 0 && qb.size() == 0) else begin
      failures++;
      $error("FAIL drain observed pending=%0d/%0d expected 0/0", qa.size(), qb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_block_ram.md
# lane_block_ram

Single-clock, one-write/one-read block RAM with per-lane write enables, selectable read-during-write behaviour, optional output pipeline register, read-valid signalling and a sequential hardware clear. It is the next generation of the switch's generic block RAM. It serves as the storage primitive under packet buffers and lookup tables that need partial-word updates and a bulk flush, without a one-cycle reset of every entry.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH
- DATA_DEPTH, 4096, number of words; need not be a power of two
- LANE_WIDTH, 8, bits per write lane; LANES = DATA_WIDTH/LANE_WIDTH
- PIPELINED_OUTPUT, 0, 0: read latency 1; 1: extra output register, latency 2
- READ_DURING_WRITE, 0, same-address read and write in one cycle: 0 returns old data, 1 returns new data with per-lane merge
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- clear  input  1  single-cycle pulse; starts a full zeroing sweep
- ready  output  1  high when reads and writes are accepted
- write_enable  input  1  write request
- write_lane_enable  input  LANES  lane i writes bits [i*LANE_WIDTH +: LANE_WIDTH]
- write_address  input  $clog2(DATA_DEPTH)  write address
- write_data  input  DATA_WIDTH  write data
- read_enable  input  1  read request
- read_address  input  $clog2(DATA_DEPTH)  read address
- read_data  output  DATA_WIDTH  read result; holds its last value when read_valid is low
- read_valid  output  1  one-cycle strobe qualifying read_data

## Operation
- Two states, held in the shared package enum: STATE_CLEARING and STATE_READY.
- Reset forces STATE_CLEARING with sweep pointer 0.
- STATE_CLEARING:
  - Each cycle writes 0 to the pointer address, then increments the pointer.
  - After address DATA_DEPTH-1 is written, the next state is STATE_READY.
  - ready = 0. write_enable and read_enable are ignored and dropped, not queued.
  - A clear pulse during the sweep is ignored.
- STATE_READY:
  - ready = 1.
  - A clear pulse zeroes the pointer and moves to STATE_CLEARING; ready drops on the next cycle. A read or write in the same cycle as the clear pulse is still accepted.
- Write accepted = write_enable & ready. Only lanes with write_lane_enable set are updated. All lanes zero means no change.
- Read accepted = read_enable & ready.
- Out-of-range addresses (>= DATA_DEPTH):
  - Write is dropped.
  - Read is accepted and returns all zeros with read_valid.
- Same-address read and write in one cycle:
  - READ_DURING_WRITE=0: read returns the pre-write word.
  - READ_DURING_WRITE=1: enabled lanes come from write_data, other lanes from memory.
- Reads accepted before a clear complete normally, returning pre-clear data.

## Timing
- Reset values: read_data 0, read_valid 0, ready 0, state STATE_CLEARING, pointer 0.
- Clear duration: ready rises exactly DATA_DEPTH clock edges after reset deasserts, or after the edge that samples clear.
- Read latency:
  - PIPELINED_OUTPUT=0: read_valid and read_data appear on the edge after acceptance.
  - PIPELINED_OUTPUT=1: one edge later.
- Throughput: one read and one write per cycle, back-to-back, with no bubbles.
- Write-to-read: data written at edge N is visible to a read accepted at edge N+1 in both modes.
- Reset asserted mid-sweep or mid-read: outputs return to reset values immediately, in-flight read_valid strobes are discarded, and the sweep restarts from 0.

## Structure
- Shared package block_ram_package holds:
  - The state enum (STATE_CLEARING, STATE_READY).
  - A lane-count function lanes(DATA_WIDTH, LANE_WIDTH).
  - Parameter-legality checks, asserted at elaboration.
- A sub-module block_ram_read_pipeline (read_data/read_valid registers plus the optional second stage) is natural. The memory array, lane-merge logic and clear FSM stay in the top module.

## Test plan
- Reset release, DATA_DEPTH=16 -> ready low for exactly 16 cycles, then high. Every address then reads 0x00000000 with read_valid one cycle after read_enable (two cycles with PIPELINED_OUTPUT=1).
- Write 0xAABBCCDD to address 5 with all lanes, then write 0x11223344 to address 5 with lane enables 4'b0101 -> a read of address 5 returns 0xAA22CC44.
- Address 7 holds 0x0; in the same cycle write 0xFFFFFFFF there with lanes 4'b0011 and read address 7 -> 0x00000000 with READ_DURING_WRITE=0, 0x0000FFFF with READ_DURING_WRITE=1.
- Fill addresses 0-15 with the value (address+1) and pulse clear -> ready low for 16 cycles. Requests issued while ready is low produce no read_valid and do not change memory. A read accepted in the clear cycle returns the pre-clear data. After ready rises, all addresses read 0.
- DATA_DEPTH=12: write to address 13 and read address 13 -> memory unchanged, read returns 0 with read_valid.
- Assert reset at sweep pointer 8, and separately with two reads in flight -> read_valid drops immediately with no late strobes, and ready rises exactly DATA_DEPTH cycles after reset deasserts.
